// File: rtl/horizontal_vga.sv
// horizontal_vga: horizontal timing generator for the 640x480@60 Hz VGA path.
//
// Divides the system clock down to the pixel rate, counts the line, and produces
// the sync pulse, the display window, the VRAM column address and the end-of-line
// strobe for the vertical stage. The colour bits from VRAM are registered once on
// their way to the pins.
//
// Optional feature: define BLANK_EN to force the colour outputs to 0 whenever the
// beam is outside the horizontal or vertical display window. Without it the
// colour is registered unconditionally and VDISPLAY is ignored.
//
// Ports:
//   clk          system clock (100 MHz)
//   reset        asynchronous active-low reset
//   VDISPLAY     vertical display window from vertical_vga
//   VRAM_RED/GREEN/BLUE  colour bits from VRAM
//   HPIXEL       7-bit VRAM column address
//   HSYNC        horizontal sync, active-low
//   HDISPLAY     1 while the current pixel is visible
//   PIXEL_TICK   one-clk pulse per pixel period
//   LINE_END     one-clk pulse on the line wrap
//   VGA_RED/GREEN/BLUE   registered colour to pins
module horizontal_vga #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned PIXEL_REP = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       VDISPLAY,
  input  logic       VRAM_RED,
  input  logic       VRAM_GREEN,
  input  logic       VRAM_BLUE,
  output logic [6:0] HPIXEL,
  output logic       HSYNC,
  output logic       HDISPLAY,
  output logic       PIXEL_TICK,
  output logic       LINE_END,
  output logic       VGA_RED,
  output logic       VGA_GREEN,
  output logic       VGA_BLUE
);

  localparam int unsigned HTotal    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned SyncStart = H_VISIBLE + H_FRONT;
  localparam int unsigned SyncEnd   = H_VISIBLE + H_FRONT + H_SYNC - 1;

  // A range of one still needs a one-bit counter.
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RepW = (PIXEL_REP > 1) ? $clog2(PIXEL_REP) : 1;
  localparam int unsigned HW   = $clog2(HTotal);

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [RepW-1:0] RepLast  = RepW'(PIXEL_REP - 1);
  localparam logic [HW-1:0]   HLast    = HW'(HTotal - 1);
  localparam logic [HW-1:0]   HVis     = HW'(H_VISIBLE);
  localparam logic [HW-1:0]   HSyncLo  = HW'(SyncStart);
  localparam logic [HW-1:0]   HSyncHi  = HW'(SyncEnd);
  localparam logic [6:0]      HPixMax  = 7'd127;

  logic [DivW-1:0] div_q, div_d;
  logic [HW-1:0]   hcount_q, hcount_d;
  logic [RepW-1:0] rep_q, rep_d;
  logic [6:0]      hpixel_q, hpixel_d;
  logic            hsync_q, hsync_d;
  logic            hdisplay_q, hdisplay_d;
  logic            tick_q, tick_d;
  logic            line_end_q, line_end_d;
  logic            red_q, red_d;
  logic            green_q, green_d;
  logic            blue_q, blue_d;
  logic            wrap;

  always_comb begin
    tick_d     = (div_q == DivLast);
    div_d      = tick_d ? '0 : div_q + 1'b1;
    wrap       = tick_d && (hcount_q == HLast);
    line_end_d = wrap;

    hcount_d = hcount_q;
    rep_d    = rep_q;
    hpixel_d = hpixel_q;

    if (wrap) begin
      hcount_d = '0;
      rep_d    = '0;
      hpixel_d = '0;
    end else if (tick_d) begin
      hcount_d = hcount_q + 1'b1;
      // Replication tracks the new pixel position; in blanking everything holds.
      if (hcount_d < HVis) begin
        if (rep_q == RepLast) begin
          rep_d = '0;
          if (hpixel_q != HPixMax) begin
            hpixel_d = hpixel_q + 1'b1;
          end
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end

    // Derived from the next count so they change on the same edge as hcount.
    hsync_d    = ~((hcount_d >= HSyncLo) && (hcount_d <= HSyncHi));
    hdisplay_d = (hcount_d < HVis);
  end

`ifdef BLANK_EN
  // Gate with the window registered on the previous clk so blanking lines up
  // with the one-clk colour latency.
  logic window;
  assign window  = hdisplay_q & VDISPLAY;
  assign red_d   = VRAM_RED & window;
  assign green_d = VRAM_GREEN & window;
  assign blue_d  = VRAM_BLUE & window;
`else
  logic unused_vdisplay;
  assign unused_vdisplay = VDISPLAY;
  assign red_d   = VRAM_RED;
  assign green_d = VRAM_GREEN;
  assign blue_d  = VRAM_BLUE;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      hcount_q   <= '0;
      rep_q      <= '0;
      hpixel_q   <= '0;
      hsync_q    <= 1'b1;
      hdisplay_q <= 1'b1;
      tick_q     <= 1'b0;
      line_end_q <= 1'b0;
      red_q      <= 1'b0;
      green_q    <= 1'b0;
      blue_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      hcount_q   <= hcount_d;
      rep_q      <= rep_d;
      hpixel_q   <= hpixel_d;
      hsync_q    <= hsync_d;
      hdisplay_q <= hdisplay_d;
      tick_q     <= tick_d;
      line_end_q <= line_end_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign HPIXEL     = hpixel_q;
  assign HSYNC      = hsync_q;
  assign HDISPLAY   = hdisplay_q;
  assign PIXEL_TICK = tick_q;
  assign LINE_END   = line_end_q;
  assign VGA_RED    = red_q;
  assign VGA_GREEN  = green_q;
  assign VGA_BLUE   = blue_q;

endmodule

// File: tb/tb_horizontal_vga.sv
// Directed bench for horizontal_vga: default instance plus a CLK_DIV = 1 instance.
module tb_horizontal_vga;

`ifdef BLANK_EN
  localparam bit Blank = 1'b1;
`else
  localparam bit Blank = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rst1_n;
  logic       vdisplay;
  logic       vram_red, vram_green, vram_blue;
  logic [6:0] hpixel;
  logic       hsync, hdisplay, pixel_tick, line_end;
  logic       vga_red, vga_green, vga_blue;

  logic [6:0] hpixel1;
  logic       hsync1, hdisplay1, tick1, le1;
  logic       red1, green1, blue1;

  horizontal_vga dut (
    .clk        (clk),
    .reset      (rst_n),
    .VDISPLAY   (vdisplay),
    .VRAM_RED   (vram_red),
    .VRAM_GREEN (vram_green),
    .VRAM_BLUE  (vram_blue),
    .HPIXEL     (hpixel),
    .HSYNC      (hsync),
    .HDISPLAY   (hdisplay),
    .PIXEL_TICK (pixel_tick),
    .LINE_END   (line_end),
    .VGA_RED    (vga_red),
    .VGA_GREEN  (vga_green),
    .VGA_BLUE   (vga_blue)
  );

  horizontal_vga #(.CLK_DIV(1)) dut1 (
    .clk        (clk),
    .reset      (rst1_n),
    .VDISPLAY   (vdisplay),
    .VRAM_RED   (vram_red),
    .VRAM_GREEN (vram_green),
    .VRAM_BLUE  (vram_blue),
    .HPIXEL     (hpixel1),
    .HSYNC      (hsync1),
    .HDISPLAY   (hdisplay1),
    .PIXEL_TICK (tick1),
    .LINE_END   (le1),
    .VGA_RED    (red1),
    .VGA_GREEN  (green1),
    .VGA_BLUE   (blue1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Signal selectors for the vector table.
  localparam int unsigned SHpix = 0, SHsync = 1, SHdisp = 2, STick = 3, SLe = 4,
                          SRed = 5, SGreen = 6;

  typedef struct {
    int unsigned phase;
    int unsigned cyc;
    int unsigned sig;
    int unsigned exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int unsigned ph, input int unsigned c, input int unsigned s,
                         input int unsigned e);
    vec_t v;
    v.phase = ph;
    v.cyc   = c;
    v.sig   = s;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] observe(input int unsigned s);
    case (s)
      SHpix:   return {25'd0, hpixel};
      SHsync:  return {31'd0, hsync};
      SHdisp:  return {31'd0, hdisplay};
      STick:   return {31'd0, pixel_tick};
      SLe:     return {31'd0, line_end};
      SRed:    return {31'd0, vga_red};
      default: return {31'd0, vga_green};
    endcase
  endfunction

  function automatic string sig_name(input int unsigned s);
    case (s)
      SHpix:   return "hpixel";
      SHsync:  return "hsync";
      SHdisp:  return "hdisplay";
      STick:   return "pixel_tick";
      SLe:     return "line_end";
      SRed:    return "vga_red";
      default: return "vga_green";
    endcase
  endfunction

  int unsigned tick1_low  = 0;
  int unsigned le1_cnt    = 0;
  int unsigned le1_first  = 0;
  int unsigned le1_last   = 0;
  int unsigned le1_period = 0;

  // Cycle c is sampled on the negedge after the c-th rising edge following release.
  task automatic run_phase(input int unsigned ph, input int unsigned ncyc);
    for (int unsigned c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      foreach (vecs[i]) begin
        if (vecs[i].phase == ph && vecs[i].cyc == c) begin
          check_val($sformatf("p%0d_%s@%0d", ph, sig_name(vecs[i].sig), c),
                    observe(vecs[i].sig), vecs[i].exp);
        end
      end
      if (ph == 0) begin
        if (!tick1) tick1_low++;
        if (le1) begin
          if (le1_cnt == 0) le1_first = c;
          else le1_period = c - le1_last;
          le1_last = c;
          le1_cnt++;
        end
      end
      vram_green = c[0];
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    rst1_n     = 1'b0;
    vdisplay   = 1'b1;
    vram_red   = 1'b1;
    vram_green = 1'b0;
    vram_blue  = 1'b0;

    // Phase 0: first line from release, then into the second line's sync pulse.
    add_vec(0, 1, STick, 0);
    add_vec(0, 3, STick, 0);
    add_vec(0, 4, STick, 1);
    add_vec(0, 5, STick, 0);
    add_vec(0, 8, STick, 1);
    add_vec(0, 3, SHpix, 0);
    add_vec(0, 3, SHsync, 1);
    add_vec(0, 3, SHdisp, 1);
    add_vec(0, 3, SLe, 0);
    add_vec(0, 19, SHpix, 0);
    add_vec(0, 20, SHpix, 1);
    add_vec(0, 39, SHpix, 1);
    add_vec(0, 40, SHpix, 2);
    add_vec(0, 2539, SHpix, 126);
    add_vec(0, 2540, SHpix, 127);
    add_vec(0, 3000, SHpix, 127);
    add_vec(0, 3199, SHpix, 127);
    add_vec(0, 3200, SHpix, 0);
    add_vec(0, 3201, SHpix, 0);
    add_vec(0, 3220, SHpix, 1);
    add_vec(0, 2623, SHsync, 1);
    add_vec(0, 2624, SHsync, 0);
    add_vec(0, 3007, SHsync, 0);
    add_vec(0, 3008, SHsync, 1);
    add_vec(0, 6001, SHsync, 0);
    add_vec(0, 2559, SHdisp, 1);
    add_vec(0, 2560, SHdisp, 0);
    add_vec(0, 3199, SHdisp, 0);
    add_vec(0, 3200, SHdisp, 1);
    add_vec(0, 3199, SLe, 0);
    add_vec(0, 3200, SLe, 1);
    add_vec(0, 3201, SLe, 0);
    add_vec(0, 100, SRed, 1);
    add_vec(0, 2560, SRed, 1);
    add_vec(0, 2561, SRed, Blank ? 0 : 1);
    add_vec(0, 2600, SRed, Blank ? 0 : 1);
    add_vec(0, 3200, SRed, Blank ? 0 : 1);
    add_vec(0, 3201, SRed, 1);
    add_vec(0, 101, SGreen, 0);
    add_vec(0, 102, SGreen, 1);
    // Phase 1: restart after a mid-line reset.
    add_vec(1, 3, SHsync, 1);
    add_vec(1, 3, STick, 0);
    add_vec(1, 4, STick, 1);
    add_vec(1, 19, SHpix, 0);
    add_vec(1, 20, SHpix, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_hpixel", {25'd0, hpixel}, 0);
    check_val("rst_hsync", {31'd0, hsync}, 1);
    check_val("rst_hdisplay", {31'd0, hdisplay}, 1);
    check_val("rst_tick", {31'd0, pixel_tick}, 0);
    check_val("rst_line_end", {31'd0, line_end}, 0);
    check_val("rst_vga_red", {31'd0, vga_red}, 0);
    check_val("rst_tick1", {31'd0, tick1}, 0);

    rst_n  = 1'b1;
    rst1_n = 1'b1;
    run_phase(0, 6001);

    check_val("div1_tick_low", tick1_low, 0);
    check_val("div1_le_first", le1_first, 800);
    check_val("div1_le_period", le1_period, 800);
    check_val("div1_le_count", le1_cnt, 7);

    // hcount is 700 here, inside the sync pulse; reset must act without a clock.
    #2 rst_n = 1'b0;
    #1;
    check_val("async_hsync", {31'd0, hsync}, 1);
    check_val("async_hpixel", {25'd0, hpixel}, 0);
    check_val("async_hdisplay", {31'd0, hdisplay}, 1);
    check_val("async_tick", {31'd0, pixel_tick}, 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_phase(1, 25);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
